// File: rtl/led_toggle_pkg.sv
// Shared constants for the multi-channel switch/LED toggler.
package led_toggle_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_FOLLOW = 1'b1;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned MAX_CH                 = 16;

    // Counter width for a given limit; a limit of 1 still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: optional two-flop synchroniser, debounce counter, stable level.
// LED_TOGGLE_SYNC_EN adds the synchroniser; without it i_Switch must already be
// synchronous to i_Clk.
module switch_debounce
    import led_toggle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Stable
);

    localparam int unsigned     CNT_W   = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             w_Synced;
    logic             r_Stable;
    logic [CNT_W-1:0] r_Count;

`ifdef LED_TOGGLE_SYNC_EN
    logic r_Sync_1;
    logic r_Sync_2;

    // Two-flop synchroniser for the asynchronous switch pin
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sync_1 <= 1'b0;
            r_Sync_2 <= 1'b0;
        end else begin
            r_Sync_1 <= i_Switch;
            r_Sync_2 <= r_Sync_1;
        end
    end

    assign w_Synced = r_Sync_2;
`else
    assign w_Synced = i_Switch;
`endif

    // Accept a new level only after DEBOUNCE_LIMIT consecutive differing cycles
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Stable <= 1'b0;
            r_Count  <= '0;
        end else if (w_Synced != r_Stable) begin
            if (r_Count == CNT_MAX) begin
                r_Stable <= w_Synced;
                r_Count  <= '0;
            end else begin
                r_Count <= r_Count + CNT_W'(1);
            end
        end else begin
            r_Count <= '0;
        end
    end

    assign o_Stable = r_Stable;

endmodule

// File: rtl/multi_switch_led_toggle.sv
// Multi-channel switch debouncer driving LEDs in toggle-on-release or follow mode.
// Build option LED_TOGGLE_SYNC_EN enables the per-channel input synchroniser.
module multi_switch_led_toggle
    import led_toggle_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic [NUM_CH-1:0] i_Mode,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Release_Pulse
);

    logic [NUM_CH-1:0] w_Stable;
    logic [NUM_CH-1:0] w_Release;
    logic [NUM_CH-1:0] r_Stable_D;
    logic [NUM_CH-1:0] r_LED;
    logic [NUM_CH-1:0] r_Release_Pulse;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Switch (i_Switch[g]),
            .o_Stable (w_Stable[g])
        );
    end

    // Release is the debounced 1->0 transition
    assign w_Release = r_Stable_D & ~w_Stable;

    // Edge-detect delay, registered release pulse and per-channel LED mode mux
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Stable_D      <= '0;
            r_Release_Pulse <= '0;
            r_LED           <= '0;
        end else begin
            r_Stable_D      <= w_Stable;
            r_Release_Pulse <= w_Release;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (i_Mode[ch] == MODE_FOLLOW) begin
                    r_LED[ch] <= w_Stable[ch];
                end else if (w_Release[ch]) begin
                    r_LED[ch] <= ~r_LED[ch];
                end
            end
        end
    end

    assign o_LED           = r_LED;
    assign o_Release_Pulse = r_Release_Pulse;

endmodule

// File: tb/tb_multi_switch_led_toggle.sv
// Self-checking bench: table of hold-level vectors with end-of-step checks, plus
// cycle-exact release and async-reset sequences.
module tb_multi_switch_led_toggle;

    localparam int unsigned DL = 4;
`ifdef LED_TOGGLE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Cycles from the edge where the input is driven to the LED/pulse update
    localparam int LAT = DL + 1 + SYNC_LAT;

    logic       i_Clk;
    logic       i_Reset;
    logic [3:0] i_Switch;
    logic [3:0] i_Mode;
    logic [3:0] o_LED;
    logic [3:0] o_Release_Pulse;

    multi_switch_led_toggle #(
        .NUM_CH         (4),
        .DEBOUNCE_LIMIT (DL)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Switch        (i_Switch),
        .i_Mode          (i_Mode),
        .o_LED           (o_LED),
        .o_Release_Pulse (o_Release_Pulse)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        string      name;
        logic [3:0] sw;
        logic [3:0] mode;
        int         hold;
        logic [3:0] exp_led;
        logic [15:0] exp_pls;   // per-channel pulse counts, one nibble each
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] led;
        logic [15:0] pls;
    } exp_t;

    vec_t vecs[21];
    exp_t sb[$];
    int   pcnt[4];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) pcnt[c] = 0;
    endtask

    function automatic logic [15:0] packed_counts();
        logic [15:0] r;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = pcnt[c][3:0];
        return r;
    endfunction

    // Advance one clock, sample outputs 1 time unit after the edge
    task automatic step();
        @(posedge i_Clk);
        #1;
        for (int c = 0; c < 4; c++) if (o_Release_Pulse[c] === 1'b1) pcnt[c]++;
    endtask

    // Drive a release and check LED/pulse on every cycle around the expected edge
    task automatic exact_release(input string nm, input logic [3:0] sw_new,
                                 input logic [3:0] led_old, input logic [3:0] led_new,
                                 input logic [3:0] pls_mask);
        exp_t e;
        i_Switch = sw_new;
        for (int k = 1; k <= LAT + 2; k++) begin
            sb.push_back('{$sformatf("%s_c%0d", nm, k),
                           {12'b0, (k >= LAT) ? led_new : led_old},
                           {12'b0, (k == LAT) ? pls_mask : 4'b0000}});
            step();
            e = sb.pop_front();
            check({e.name, "_led"}, {12'b0, o_LED}, e.led);
            check({e.name, "_pls"}, {12'b0, o_Release_Pulse}, e.pls);
        end
    endtask

    initial begin
        exp_t e;
        i_Reset  = 1'b1;
        i_Switch = 4'b0000;
        i_Mode   = 4'b0000;
        clear_counts();
        repeat (3) step();
        check("reset_led", {12'b0, o_LED}, 16'h0000);
        check("reset_pls", {12'b0, o_Release_Pulse}, 16'h0000);
        i_Reset = 1'b0;

        vecs[0]  = '{"idle",        4'b0000, 4'b0000, 50, 4'b0000, 16'h0000};
        vecs[1]  = '{"c0_press",    4'b0001, 4'b0000, 12, 4'b0000, 16'h0000};
        vecs[2]  = '{"c0_rel",      4'b0000, 4'b0000, 12, 4'b0001, 16'h0001};
        vecs[3]  = '{"c0_press2",   4'b0001, 4'b0000, 12, 4'b0001, 16'h0000};
        vecs[4]  = '{"c0_rel2",     4'b0000, 4'b0000, 12, 4'b0000, 16'h0001};
        vecs[5]  = '{"c1_b1a",      4'b0010, 4'b0000,  2, 4'b0000, 16'h0000};
        vecs[6]  = '{"c1_b0a",      4'b0000, 4'b0000,  2, 4'b0000, 16'h0000};
        vecs[7]  = '{"c1_b1b",      4'b0010, 4'b0000,  2, 4'b0000, 16'h0000};
        vecs[8]  = '{"c1_settle",   4'b0000, 4'b0000, 12, 4'b0000, 16'h0000};
        vecs[9]  = '{"c1_b1c",      4'b0010, 4'b0000,  2, 4'b0000, 16'h0000};
        vecs[10] = '{"c1_b0c",      4'b0000, 4'b0000,  2, 4'b0000, 16'h0000};
        vecs[11] = '{"c1_hold",     4'b0010, 4'b0000, 12, 4'b0000, 16'h0000};
        vecs[12] = '{"c1_rel",      4'b0000, 4'b0000, 12, 4'b0010, 16'h0010};
        vecs[13] = '{"c2_follow0",  4'b0000, 4'b0100, 12, 4'b0010, 16'h0000};
        vecs[14] = '{"c2_fpress",   4'b0100, 4'b0100, 20, 4'b0110, 16'h0000};
        vecs[15] = '{"c2_frel",     4'b0000, 4'b0100, 12, 4'b0010, 16'h0100};
        vecs[16] = '{"c2_fpress2",  4'b0100, 4'b0100, 12, 4'b0110, 16'h0000};
        vecs[17] = '{"c2_to_tog",   4'b0100, 4'b0000, 12, 4'b0110, 16'h0000};
        vecs[18] = '{"c2_trel",     4'b0000, 4'b0000, 12, 4'b0010, 16'h0100};
        vecs[19] = '{"all_press",   4'b1111, 4'b0000, 12, 4'b0010, 16'h0000};
        vecs[20] = '{"all_rel",     4'b0000, 4'b0000, 12, 4'b1101, 16'h1111};

        for (int i = 0; i < 21; i++) begin
            i_Switch = vecs[i].sw;
            i_Mode   = vecs[i].mode;
            clear_counts();
            sb.push_back('{vecs[i].name, {12'b0, vecs[i].exp_led}, vecs[i].exp_pls});
            repeat (vecs[i].hold) step();
            e = sb.pop_front();
            check({e.name, "_led"}, {12'b0, o_LED}, e.led);
            check({e.name, "_pls"}, packed_counts(), e.pls);
        end

        // Async reset mid-debounce with ch3 held; LEDs are 1101 going in
        i_Switch = 4'b1000;
        repeat (2) step();
        #2;
        i_Reset = 1'b1;
        #1;
        check("async_rst_led", {12'b0, o_LED}, 16'h0000);
        check("async_rst_pls", {12'b0, o_Release_Pulse}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst_hold%0d_led", k), {12'b0, o_LED}, 16'h0000);
        end
        i_Reset = 1'b0;
        clear_counts();
        repeat (20) step();
        check("requal_led", {12'b0, o_LED}, 16'h0000);
        check("requal_pls", packed_counts(), 16'h0000);

        // Remaining channels join the held ch3, then all release on one edge
        i_Switch = 4'b1111;
        repeat (12) step();
        check("all_held_led", {12'b0, o_LED}, 16'h0000);
        exact_release("all_exact", 4'b0000, 4'b0000, 4'b1111, 4'b1111);

        // Single-channel cycle-exact release on ch0
        i_Switch = 4'b0001;
        repeat (10) step();
        exact_release("c0_exact", 4'b0000, 4'b1111, 4'b1110, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
